// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: MOV/MOC handshake in front of a word-organised synchronous RAM,
// with byte/halfword/word big-endian lanes, programmable wait states and load formatting.
module mem_access_ctrl #(
    parameter int WORD_AW     = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               MOV,
    input  logic               RW,
    input  logic [1:0]         SIZE,
    input  logic               SIGNED,
    input  logic [31:0]        ADDR,
    input  logic [31:0]        WDATA,
    output logic [31:0]        RDATA,
    output logic               MOC,
    output logic               ERR,
    output logic               BUSY,
    output logic               MEM_EN,
    output logic [3:0]         MEM_WE,
    output logic [WORD_AW-1:0] MEM_ADDR,
    output logic [31:0]        MEM_WDATA,
    input  logic [31:0]        MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t             state, state_nxt;
    logic               rw_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [WORD_AW+1:0] addr_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [3:0]         cnt_q;
    logic               misaligned;
    logic [1:0]         off;
    logic [3:0]         store_we;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        load_fmt;
    logic               unused_addr;

    // Address bits above the RAM are dropped, so accesses wrap modulo the RAM size.
    assign unused_addr = ^ADDR[31:WORD_AW+2];
    assign off         = addr_q[1:0];
    assign MEM_ADDR    = addr_q[WORD_AW+1:2];

    always_comb begin
        misaligned = (SIZE == 2'b11) || ((SIZE == 2'b01) && ADDR[0]) ||
                     ((SIZE == 2'b10) && (ADDR[1:0] != 2'b00));
    end

    always_comb begin
        store_we  = 4'b1111;
        MEM_WDATA = wdata_q;
        case (size_q)
            2'b00: begin
                store_we  = 4'b1000 >> off;
                MEM_WDATA = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_we  = off[1] ? 4'b0011 : 4'b1100;
                MEM_WDATA = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = MEM_RDATA[31:24];
        case (off)
            2'd1:    lane_b = MEM_RDATA[23:16];
            2'd2:    lane_b = MEM_RDATA[15:8];
            2'd3:    lane_b = MEM_RDATA[7:0];
            default: ;
        endcase
        lane_h = off[1] ? MEM_RDATA[15:0] : MEM_RDATA[31:16];
        case (size_q)
            2'b00:   load_fmt = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_fmt = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_fmt = MEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            rw_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 4'd0;
            RDATA    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && MOV) begin
                rw_q     <= RW;
                size_q   <= SIZE;
                signed_q <= SIGNED;
                addr_q   <= ADDR[WORD_AW+1:0];
                wdata_q  <= WDATA;
                err_q    <= misaligned;
                cnt_q    <= WAIT_LOAD;
            end
            if ((state == S_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state == S_CAPTURE) begin
                RDATA <= load_fmt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        MOC       = 1'b0;
        ERR       = 1'b0;
        BUSY      = 1'b1;
        MEM_EN    = 1'b0;
        MEM_WE    = 4'b0000;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (MOV) begin
                    if (misaligned)           state_nxt = S_DONE;
                    else if (WAIT_CYCLES > 0) state_nxt = S_WAIT;
                    else                      state_nxt = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                MEM_EN    = 1'b1;
                MEM_WE    = rw_q ? 4'b0000 : store_we;
                state_nxt = rw_q ? S_CAPTURE : S_DONE;
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE: begin
                MOC = 1'b1;
                ERR = err_q;
                if (!MOV) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access sequencer between the CPU datapath and word-organised synchronous data RAM. It takes a request from the control unit, with the address from MAR and the store data from MDR. It performs byte, halfword or word loads and stores with a programmable wait-state count, and returns load data formatted for the MDR input mux. Completion is signalled with a four-phase MOV/MOC handshake.

Parameters:
WORD_AW, 8, RAM word-address width (RAM depth = 2**WORD_AW words).
WAIT_CYCLES, 2, wait states inserted before the RAM access (0..15; 0 means no WAIT state).

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
MOV  input  1  memory operation valid (request) from control unit
RW  input  1  1 = load, 0 = store
SIZE  input  2  00 byte, 01 halfword, 10 word, 11 reserved
SIGNED  input  1  sign-extend load data (byte/halfword only)
ADDR  input  32  byte address (MAR output)
WDATA  input  32  store data (MDR output); low-order bits used for byte/halfword
RDATA  output  32  formatted load data to MDR input mux
MOC  output  1  memory operation complete
ERR  output  1  request rejected (misaligned or reserved SIZE); valid while MOC=1
BUSY  output  1  high in every state except IDLE
MEM_EN  output  1  RAM access strobe
MEM_WE  output  4  per-byte write enables, bit 3 = bits 31:24
MEM_ADDR  output  WORD_AW  RAM word address
MEM_WDATA  output  32  RAM write data
MEM_RDATA  input  32  RAM read data, valid the cycle after MEM_EN with MEM_WE=0

Behaviour:
- Clock and reset: single clock CLK; reset RST_N asynchronous, active-low.
- Reset values: state IDLE; MOC=0, ERR=0, BUSY=0, RDATA=0, MEM_EN=0, MEM_WE=0.
- Latched request fields: RW, SIZE, SIGNED, ADDR, WDATA.
- MEM_* outputs: combinational from the current state and the latched fields.
- States: IDLE, WAIT, ACCESS, CAPTURE, DONE.
- IDLE: MOV=1 at an edge latches the request fields.
  - If misaligned, go to DONE with ERR=1. Misaligned means SIZE=11, halfword with ADDR[0]=1, or word with ADDR[1:0]!=0.
  - Otherwise go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
- WAIT: 4-bit down-counter loaded with WAIT_CYCLES-1. Go to ACCESS when it reaches 0. State lasts exactly WAIT_CYCLES cycles.
- ACCESS: MEM_EN=1 for exactly one cycle; MEM_ADDR=ADDR[WORD_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
  - Load: MEM_WE=0000, go to CAPTURE.
  - Store: go to DONE.
- Store lanes (big-endian, byte offset 0 = bits 31:24):
  - Byte: WDATA[7:0] replicated to all four lanes; MEM_WE=1000 >> ADDR[1:0].
  - Halfword: WDATA[15:0] replicated to both halves; MEM_WE=1100 at offset 0, 0011 at offset 2.
  - Word: MEM_WDATA=WDATA, MEM_WE=1111.
- CAPTURE: select the lane from MEM_RDATA using the latched offset. Zero-extend, or sign-extend when SIGNED=1; SIGNED is ignored for word loads. Register the result into RDATA at the edge, then go to DONE.
- RDATA: holds its value until the next successful load. It is not changed by stores or error completions.
- DONE: MOC=1, and ERR is held from the request check.
  - Leave to IDLE on the first edge where MOV=0; MOC and ERR drop in that same transition.
  - MOV held high keeps the block in DONE, so there is no re-trigger without MOV going low.
- Latency, counted from the IDLE edge that samples MOV, with W=WAIT_CYCLES:
  - Store: MOC high after edge W+2.
  - Load: MOC high after edge W+3.
  - Error: MOC high after edge 1.
- Request fields: changes on MOV/ADDR/WDATA/SIZE after the sampling edge are ignored. MOV dropping early does not abort the operation; DONE then lasts one cycle.
- RST_N low mid-operation: immediate abort with all outputs at reset values. A write never issues after reset is asserted.

Test Plan:
- W=2, store word 0xDEADBEEF @0x10, then load word @0x10 -> MEM_WE=1111 once at MEM_ADDR=4; load MOC after edge 5, RDATA=0xDEADBEEF.
- Store byte 0x5A @0x13 into word 0x11223344 -> MEM_WE=0001, MEM_WDATA=0x5A5A5A5A; reload word gives 0x1122335A.
- Load byte @0x11 of word 0x0080FF00, SIGNED=1 -> RDATA=0xFFFFFF80; SIGNED=0 -> 0x00000080. Load halfword @0x12 with SIGNED=1 -> 0xFFFFFF00.
- Load word @0x06 -> MOC after edge 1, ERR=1, MEM_EN never 1, RDATA unchanged; same for SIZE=11 and halfword @0x01.
- MOV held high 5 cycles after MOC -> single access only, MOC held for all 5 cycles; MOV dropped right after sampling -> MOC one-cycle pulse.
- RST_N asserted low during WAIT of a store -> MOC/BUSY/MEM_EN go 0 immediately, no write occurs; WAIT_CYCLES=0 store -> MOC after edge 2.
